// File: rtl/qedmma_link_pkg.sv
// Shared constants and types for the QEDMMA link-health blocks.
// Ping/pong magic words (ASCII "QEDMPING"/"QEDMPONG") and the TX arbiter state encoding.
package qedmma_link_pkg;

  localparam logic [63:0] PING_MAGIC = 64'h5145_444D_5049_4E47;
  localparam logic [63:0] PONG_MAGIC = 64'h5145_444D_504F_4E47;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PONG = 2'd1,
    ST_USER = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/link_tx_frame_mux.sv
// Frame-boundary two-source arbiter; the priority source wins at every boundary.
// Latency: zero once a source is granted; one idle (ST_IDLE) cycle between frames.
// Backpressure: out_ready goes straight to the granted source; a frame is never interrupted.
module link_tx_frame_mux
  import qedmma_link_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pri_req,
  input  logic [DATA_WIDTH-1:0] pri_data,
  input  logic                  pri_valid,
  input  logic                  pri_last,
  output logic                  pri_ready,
  input  logic [DATA_WIDTH-1:0] sec_data,
  input  logic                  sec_valid,
  input  logic                  sec_last,
  output logic                  sec_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  tx_arb_state_t state;

  // pri_req is only looked at in ST_IDLE; once granted the priority source
  // is driven from pri_valid so an in-flight frame completes even if its request drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pri_req)        state <= ST_PONG;
          else if (sec_valid) state <= ST_USER;
        end
        ST_PONG: if (pri_valid && out_ready && pri_last) state <= ST_IDLE;
        ST_USER: if (sec_valid && out_ready && sec_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    pri_ready = 1'b0;
    sec_ready = 1'b0;
    unique case (state)
      ST_PONG: begin
        out_data  = pri_data;
        out_valid = pri_valid;
        out_last  = pri_last;
        pri_ready = out_ready;
      end
      ST_USER: begin
        out_data  = sec_data;
        out_valid = sec_valid;
        out_last  = sec_last;
        sec_ready = out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/link_echo_responder.sv
// Ping responder: strips single-beat ping frames from RX, queues pongs and merges them into TX ahead of user frames.
// Latency: RX and user-TX passthrough 0 cycles; ping accepted in cycle N -> pong tx_valid in cycle N+2.
// Backpressure: pings always consumed (dropped when QUEUE_DEPTH pongs pending); stats counters built only with LINK_ECHO_STATS_EN.
module link_echo_responder
  import qedmma_link_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [DATA_WIDTH-1:0]          rx_data,
  input  logic                           rx_valid,
  input  logic                           rx_last,
  output logic                           rx_ready,
  output logic [DATA_WIDTH-1:0]          usr_rx_data,
  output logic                           usr_rx_valid,
  output logic                           usr_rx_last,
  input  logic                           usr_rx_ready,
  input  logic [DATA_WIDTH-1:0]          usr_tx_data,
  input  logic                           usr_tx_valid,
  input  logic                           usr_tx_last,
  output logic                           usr_tx_ready,
  output logic [DATA_WIDTH-1:0]          tx_data,
  output logic                           tx_valid,
  output logic                           tx_last,
  input  logic                           tx_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
  output logic [31:0]                    pings_rx,
  output logic [31:0]                    pongs_tx,
  output logic [31:0]                    pings_dropped
);

  localparam int PW = $clog2(QUEUE_DEPTH + 1);

  logic          rx_sof;
  logic          ping_beat;
  logic          pend_full;
  logic          ping_queue;
  logic          pong_hs;
  logic          pong_req;
  logic [PW-1:0] pending_q;

  assign ping_beat = enable && rx_sof && rx_valid && rx_last && (rx_data[63:0] == PING_MAGIC);

  assign rx_ready     = !rst && (ping_beat || usr_rx_ready);
  assign usr_rx_valid = !rst && rx_valid && !ping_beat;
  assign usr_rx_data  = rx_data;
  assign usr_rx_last  = rx_last;

  // Frame position is tracked even while disabled so enabling mid-frame is safe.
  always_ff @(posedge clk) begin
    if (rst)                       rx_sof <= 1'b1;
    else if (rx_valid && rx_ready) rx_sof <= rx_last;
  end

  assign pend_full  = (pending_q == PW'(QUEUE_DEPTH));
  assign ping_queue = ping_beat && !pend_full;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      pending_q <= '0;
    end else begin
      unique case ({ping_queue, pong_hs && (pending_q != '0)})
        2'b10:   pending_q <= pending_q + PW'(1);
        2'b01:   pending_q <= pending_q - PW'(1);
        default: pending_q <= pending_q;
      endcase
    end
  end

  assign pending  = pending_q;
  assign pong_req = enable && (pending_q != '0);

  link_tx_frame_mux #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx_mux (
    .clk       (clk),
    .rst       (rst),
    .pri_req   (pong_req),
    .pri_data  (DATA_WIDTH'(PONG_MAGIC)),
    .pri_valid (1'b1),
    .pri_last  (1'b1),
    .pri_ready (pong_hs),
    .sec_data  (usr_tx_data),
    .sec_valid (usr_tx_valid),
    .sec_last  (usr_tx_last),
    .sec_ready (usr_tx_ready),
    .out_data  (tx_data),
    .out_valid (tx_valid),
    .out_last  (tx_last),
    .out_ready (tx_ready)
  );

`ifdef LINK_ECHO_STATS_EN
  logic        ping_drop;
  logic [31:0] pings_rx_q;
  logic [31:0] pongs_tx_q;
  logic [31:0] pings_dropped_q;

  assign ping_drop = ping_beat && pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      pings_rx_q      <= '0;
      pongs_tx_q      <= '0;
      pings_dropped_q <= '0;
    end else begin
      if (ping_beat) pings_rx_q      <= pings_rx_q + 32'd1;
      if (pong_hs)   pongs_tx_q      <= pongs_tx_q + 32'd1;
      if (ping_drop) pings_dropped_q <= pings_dropped_q + 32'd1;
    end
  end

  assign pings_rx      = pings_rx_q;
  assign pongs_tx      = pongs_tx_q;
  assign pings_dropped = pings_dropped_q;
`else
  assign pings_rx      = '0;
  assign pongs_tx      = '0;
  assign pings_dropped = '0;
`endif

endmodule

// File: tb/tb_link_echo_responder.sv
// Bench for link_echo_responder: directed scenarios plus randomized traffic against an abstract
// pending-count / frame-order model kept here.
`timescale 1ns/1ps
module tb_link_echo_responder;

  localparam int DW = 64;
  localparam int QD = 4;
  localparam int PW = $clog2(QD + 1);
  localparam logic [63:0] PING_W = 64'h5145_444D_5049_4E47;
  localparam logic [63:0] PONG_W = 64'h5145_444D_504F_4E47;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [DW-1:0] rx_data, usr_rx_data, usr_tx_data, tx_data;
  logic          rx_valid, rx_last, rx_ready;
  logic          usr_rx_valid, usr_rx_last, usr_rx_ready;
  logic          usr_tx_valid, usr_tx_last, usr_tx_ready;
  logic          tx_valid, tx_last, tx_ready;
  logic [PW-1:0] pending;
  logic [31:0]   pings_rx, pongs_tx, pings_dropped;

  link_echo_responder #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .usr_rx_data(usr_rx_data), .usr_rx_valid(usr_rx_valid), .usr_rx_last(usr_rx_last),
    .usr_rx_ready(usr_rx_ready),
    .usr_tx_data(usr_tx_data), .usr_tx_valid(usr_tx_valid), .usr_tx_last(usr_tx_last),
    .usr_tx_ready(usr_tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .pending(pending), .pings_rx(pings_rx), .pongs_tx(pongs_tx), .pings_dropped(pings_dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Abstract model: pongs owed, stats, and RX frame position, advanced once per cycle.
  int m_pend = 0, m_pings = 0, m_pongs = 0, m_drops = 0;
  bit m_sof = 1'b1;
  bit cur_ping, cur_pong, cur_rx_acc, cur_tx_hs;

  function automatic int st(int v);
`ifdef LINK_ECHO_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    bit queued;
    @(negedge clk);
    cur_ping   = enable && m_sof && rx_valid && rx_last && (rx_data == PING_W);
    cur_rx_acc = rx_valid && (cur_ping || usr_rx_ready);
    cur_tx_hs  = tx_valid && tx_ready;
    cur_pong   = cur_tx_hs && tx_last && (tx_data == PONG_W);
    if (rst) begin
      m_pend = 0; m_pings = 0; m_pongs = 0; m_drops = 0; m_sof = 1'b1;
    end else begin
      queued = cur_ping && (m_pend < QD);
      if (cur_rx_acc) m_sof = rx_last;
      if (cur_ping) m_pings++;
      if (cur_ping && !queued) m_drops++;
      if (cur_pong) m_pongs++;
      if (!enable) m_pend = 0;
      else m_pend = m_pend + (queued ? 1 : 0) - ((cur_pong && m_pend > 0) ? 1 : 0);
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1;
    rx_valid = 1'b0; rx_last = 1'b0; rx_data = '0; usr_rx_ready = 1'b1;
    usr_tx_valid = 1'b0; usr_tx_last = 1'b0; usr_tx_data = '0; tx_ready = 1'b1;
  endtask

  task automatic drive_ping();
    rx_valid = 1'b1; rx_last = 1'b1; rx_data = PING_W;
  endtask

  task automatic do_reset();
    tick(); idle_inputs(); rst = 1'b1; sample();
    tick(); sample();
    tick(); rst = 1'b0; sample();
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; drive_ping(); usr_tx_valid = 1'b1; usr_tx_data = {$urandom, $urandom};
    sample();
    total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    total++; if (usr_rx_valid !== 1'b0) begin bad++; $display("FAIL rst_usr_rx_valid: got %b want 0", usr_rx_valid); end
    tick();
    total++; if ({tx_valid, tx_last, usr_tx_ready} !== 3'b000) begin bad++; $display("FAIL rst_tx_ctl: got %b want 000", {tx_valid, tx_last, usr_tx_ready}); end
    total++; if (tx_data !== '0) begin bad++; $display("FAIL rst_tx_data: got %h want 0", tx_data); end
    total++; if (pending !== '0) begin bad++; $display("FAIL rst_pending: got %0d want 0", pending); end
    total++; if ({pings_rx, pongs_tx, pings_dropped} !== 96'd0) begin bad++; $display("FAIL rst_counters: got %0d/%0d/%0d want 0", pings_rx, pongs_tx, pings_dropped); end
    sample();
    tick(); rst = 1'b0; idle_inputs(); sample();
  endtask

  task automatic test_single_ping();
    do_reset();
    tick(); drive_ping(); sample();
    total++; if (usr_rx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL ping_consumed: usr_rx_valid=%b rx_ready=%b want 0/1", usr_rx_valid, rx_ready); end
    tick(); rx_valid = 1'b0;
    total++; if (pending !== PW'(1)) begin bad++; $display("FAIL ping_pending: got %0d want 1", pending); end
    sample();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL pong_early: tx_valid=%b want 0", tx_valid); end
    tick(); sample();
    total++; if (tx_valid !== 1'b1 || tx_data !== PONG_W || tx_last !== 1'b1) begin bad++; $display("FAIL pong_n2: valid=%b data=%h last=%b want 1/%h/1", tx_valid, tx_data, tx_last, PONG_W); end
    tick(); sample();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL pong_bubble: tx_valid=%b want 0", tx_valid); end
    total++; if (pongs_tx !== 32'(st(1)) || pings_rx !== 32'(st(1))) begin bad++; $display("FAIL ping_stats: pongs=%0d pings=%0d want %0d", pongs_tx, pings_rx, st(1)); end
  endtask

  task automatic test_overflow();
    int hs[$];
    do_reset();
    for (int i = 0; i < 6; i++) begin tick(); tx_ready = 1'b0; drive_ping(); sample(); end
    tick(); rx_valid = 1'b0;
    total++; if (pending !== PW'(QD)) begin bad++; $display("FAIL ovf_pending: got %0d want %0d", pending, QD); end
    total++; if (pings_dropped !== 32'(st(2)) || pings_rx !== 32'(st(6))) begin bad++; $display("FAIL ovf_stats: dropped=%0d pings=%0d want %0d/%0d", pings_dropped, pings_rx, st(2), st(6)); end
    total++; if (tx_valid !== 1'b1 || tx_data !== PONG_W) begin bad++; $display("FAIL ovf_held: valid=%b data=%h want 1/%h", tx_valid, tx_data, PONG_W); end
    sample();
    for (int c = 0; c < 20; c++) begin
      tick(); tx_ready = 1'b1; sample();
      if (cur_pong) hs.push_back(c);
    end
    total++; if (hs.size() != QD) begin bad++; $display("FAIL ovf_pong_count: got %0d want %0d", hs.size(), QD); end
    for (int i = 1; i < hs.size(); i++) begin
      total++; if (hs[i] - hs[i-1] != 2) begin bad++; $display("FAIL ovf_gap: got %0d want 2", hs[i] - hs[i-1]); end
    end
    total++; if (pending !== '0) begin bad++; $display("FAIL ovf_drained: got %0d want 0", pending); end
  endtask

  task automatic test_pong_waits();
    logic [63:0] pay [8];
    int idx = 0, nuser = 0, last_c = -1, pong_c = -1;
    bit ping_sent = 0;
    do_reset();
    for (int i = 0; i < 8; i++) pay[i] = {$urandom, $urandom};
    for (int c = 0; c < 40; c++) begin
      tick();
      usr_tx_valid = (idx < 8);
      usr_tx_data  = (idx < 8) ? pay[idx] : '0;
      usr_tx_last  = (idx == 7);
      if (idx == 3 && !ping_sent) drive_ping(); else rx_valid = 1'b0;
      sample();
      if (cur_ping) ping_sent = 1;
      if (cur_tx_hs && cur_pong && pong_c < 0) pong_c = c;
      if (cur_tx_hs && !cur_pong) begin
        total++;
        if (nuser >= 8 || tx_data !== pay[nuser] || pong_c >= 0) begin
          bad++; $display("FAIL wait_user_beat%0d: got %h (pong_at=%0d) want %h", nuser, tx_data, pong_c, (nuser < 8) ? pay[nuser] : 64'h0);
        end
        if (tx_last) last_c = c;
        nuser++;
      end
      if (usr_tx_valid && usr_tx_ready) idx++;
    end
    total++; if (!ping_sent || nuser != 8) begin bad++; $display("FAIL wait_frame: ping=%0d user_beats=%0d want 1/8", ping_sent, nuser); end
    total++; if (last_c < 0 || pong_c != last_c + 2) begin bad++; $display("FAIL wait_pong_cycle: got %0d want %0d", pong_c, last_c + 2); end
  endtask

  task automatic test_magic_midframe();
    logic [63:0] bd [9];
    bit bl [9];
    int idx = 0;
    do_reset();
    bd = '{64'h0123, PING_W, 64'h4567, 64'h89AB, PING_W, 64'hCDEF, 64'h1111, 64'h2222, PING_W};
    bl = '{0, 0, 0, 1, 0, 1, 0, 0, 1};
    for (int c = 0; c < 60 && idx < 9; c++) begin
      tick();
      usr_rx_ready = ($urandom_range(0, 3) != 0);
      rx_valid = 1'b1; rx_data = bd[idx]; rx_last = bl[idx];
      sample();
      total++;
      if (usr_rx_valid !== 1'b1 || usr_rx_data !== rx_data || usr_rx_last !== rx_last || rx_ready !== usr_rx_ready) begin
        bad++; $display("FAIL mid_fwd%0d: vld=%b data=%h rdy=%b want 1/%h/%b", idx, usr_rx_valid, usr_rx_data, rx_ready, rx_data, usr_rx_ready);
      end
      if (rx_ready) idx++;
    end
    tick(); rx_valid = 1'b0; usr_rx_ready = 1'b1;
    total++; if (idx != 9) begin bad++; $display("FAIL mid_done: got %0d beats want 9", idx); end
    total++; if (pings_rx !== 32'(st(0)) || pending !== '0) begin bad++; $display("FAIL mid_no_ping: pings=%0d pending=%0d want 0/0", pings_rx, pending); end
    sample();
  endtask

  task automatic test_disable();
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin tick(); tx_ready = 1'b0; drive_ping(); sample(); end
    tick(); rx_valid = 1'b0;
    total++; if (pending !== PW'(3) || tx_valid !== 1'b1 || tx_data !== PONG_W) begin bad++; $display("FAIL dis_setup: pending=%0d tx_valid=%b want 3/1", pending, tx_valid); end
    sample();
    tick(); enable = 1'b0; sample();
    tick();
    total++; if (pending !== '0) begin bad++; $display("FAIL dis_pending: got %0d want 0", pending); end
    total++; if (tx_valid !== 1'b1 || tx_data !== PONG_W) begin bad++; $display("FAIL dis_pong_held: valid=%b data=%h want 1/%h", tx_valid, tx_data, PONG_W); end
    drive_ping(); usr_rx_ready = 1'b1;
    sample();
    total++; if (usr_rx_valid !== 1'b1 || usr_rx_data !== PING_W || rx_ready !== 1'b1) begin bad++; $display("FAIL dis_ping_fwd: vld=%b data=%h rdy=%b want 1/%h/1", usr_rx_valid, usr_rx_data, rx_ready, PING_W); end
    for (int c = 0; c < 10; c++) begin
      tick(); rx_valid = 1'b0; tx_ready = 1'b1; sample();
      if (cur_pong) n++;
    end
    total++; if (n != 1) begin bad++; $display("FAIL dis_pong_count: got %0d want 1", n); end
    total++; if (pending !== '0 || pongs_tx !== 32'(st(1)) || pings_rx !== 32'(st(3))) begin bad++; $display("FAIL dis_final: pending=%0d pongs=%0d pings=%0d", pending, pongs_tx, pings_rx); end
    tick(); enable = 1'b1; sample();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 2; i++) begin tick(); tx_ready = 1'b0; drive_ping(); sample(); end
    tick();
    total++; if (pending !== PW'(2) || tx_valid !== 1'b1) begin bad++; $display("FAIL sim_setup: pending=%0d tx_valid=%b want 2/1", pending, tx_valid); end
    drive_ping(); tx_ready = 1'b1;
    sample();
    total++; if (!cur_pong || !cur_ping) begin bad++; $display("FAIL sim_both: pong_hs=%0d ping=%0d want 1/1", cur_pong, cur_ping); end
    tick(); rx_valid = 1'b0; tx_ready = 1'b0;
    total++; if (pending !== PW'(2)) begin bad++; $display("FAIL sim_pending: got %0d want 2", pending); end
    sample();
    for (int c = 0; c < 6; c++) begin
      tick();
      tx_ready = 1'b1; usr_tx_valid = 1'b1; usr_tx_last = 1'b0; usr_tx_data = {$urandom, $urandom};
      rx_valid = 1'b1; rx_last = 1'b0; rx_data = {$urandom, $urandom};
      sample();
    end
    tick(); rst = 1'b1; sample();
    total++; if (rx_ready !== 1'b0 || usr_rx_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rx: rdy=%b vld=%b want 0/0", rx_ready, usr_rx_valid); end
    tick();
    total++; if ({tx_valid, tx_last, usr_tx_ready} !== 3'b000 || tx_data !== '0) begin bad++; $display("FAIL rstmid_tx: ctl=%b data=%h want 000/0", {tx_valid, tx_last, usr_tx_ready}, tx_data); end
    total++; if (pending !== '0 || pongs_tx !== 32'd0 || pings_rx !== 32'd0) begin bad++; $display("FAIL rstmid_state: pending=%0d pongs=%0d pings=%0d want 0", pending, pongs_tx, pings_rx); end
    sample();
    tick(); rst = 1'b0; usr_tx_valid = 1'b0; drive_ping(); sample();
    total++; if (usr_rx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL rstmid_sof: vld=%b rdy=%b want 0/1", usr_rx_valid, rx_ready); end
    tick(); rx_valid = 1'b0; sample();
  endtask

  task automatic test_random();
    int rx_rem = 0, ut_rem = 0;
    bit rx_hold = 0, ut_hold = 0, in_user = 0, stall = 0, drain;
    logic [63:0] s_data;
    bit s_last;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      drain = (c >= 600);
      tick();
      total++; if (pending !== PW'(m_pend)) begin bad++; $display("FAIL rnd_pending c%0d: got %0d want %0d", c, pending, m_pend); end
      usr_rx_ready = drain || ($urandom_range(0, 3) != 0);
      tx_ready     = drain || ($urandom_range(0, 2) != 0);
      if (!rx_hold) begin
        if (rx_rem == 0 && (drain || $urandom_range(0, 3) == 0)) rx_valid = 1'b0;
        else begin
          if (rx_rem == 0) rx_rem = $urandom_range(1, 3);
          rx_data = ($urandom_range(0, 1) == 0) ? PING_W : {$urandom, $urandom};
          rx_last = (rx_rem == 1); rx_rem--; rx_valid = 1'b1; rx_hold = 1;
        end
      end
      if (!ut_hold) begin
        if (ut_rem == 0 && (drain || $urandom_range(0, 2) == 0)) usr_tx_valid = 1'b0;
        else begin
          if (ut_rem == 0) ut_rem = $urandom_range(1, 4);
          usr_tx_data = {$urandom, $urandom}; usr_tx_last = (ut_rem == 1); ut_rem--;
          usr_tx_valid = 1'b1; ut_hold = 1;
        end
      end
      sample();
      total++;
      if (rx_valid && cur_ping) begin
        if (usr_rx_valid !== 1'b0 || rx_ready !== 1'b1) begin bad++; $display("FAIL rnd_ping c%0d: vld=%b rdy=%b want 0/1", c, usr_rx_valid, rx_ready); end
      end else if (usr_rx_valid !== rx_valid || (rx_valid && (usr_rx_data !== rx_data || rx_ready !== usr_rx_ready))) begin
        bad++; $display("FAIL rnd_rx_pass c%0d: vld=%b data=%h rdy=%b want %b/%h/%b", c, usr_rx_valid, usr_rx_data, rx_ready, rx_valid, rx_data, usr_rx_ready);
      end
      if (stall) begin
        total++; if (tx_valid !== 1'b1 || tx_data !== s_data || tx_last !== s_last) begin bad++; $display("FAIL rnd_tx_stable c%0d: got %b/%h want 1/%h", c, tx_valid, tx_data, s_data); end
      end
      if (tx_valid && tx_data !== PONG_W) begin
        total++; if (tx_data !== usr_tx_data || tx_last !== usr_tx_last || usr_tx_valid !== 1'b1 || usr_tx_ready !== tx_ready) begin bad++; $display("FAIL rnd_tx_pass c%0d: data=%h last=%b want %h/%b", c, tx_data, tx_last, usr_tx_data, usr_tx_last); end
      end
      if (in_user) begin
        total++; if (tx_valid && tx_data === PONG_W) begin bad++; $display("FAIL rnd_pong_in_frame c%0d: got pong want user beat", c); end
      end
      if (cur_tx_hs && !cur_pong) in_user = !tx_last;
      stall = tx_valid && !tx_ready; s_data = tx_data; s_last = tx_last;
      if (cur_rx_acc) rx_hold = 0;
      if (usr_tx_valid && usr_tx_ready) ut_hold = 0;
    end
    total++; if (pending !== '0 || m_pongs != m_pings - m_drops) begin bad++; $display("FAIL rnd_conserve: pending=%0d pongs=%0d want %0d", pending, m_pongs, m_pings - m_drops); end
    total++; if (pings_rx !== 32'(st(m_pings)) || pongs_tx !== 32'(st(m_pongs)) || pings_dropped !== 32'(st(m_drops))) begin
      bad++; $display("FAIL rnd_stats: got %0d/%0d/%0d want %0d/%0d/%0d", pings_rx, pongs_tx, pings_dropped, st(m_pings), st(m_pongs), st(m_drops));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_ping();
    test_overflow();
    test_pong_waits();
    test_magic_midframe();
    test_disable();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_echo_responder.md
# link_echo_responder

Far-end ping responder for the QEDMMA comm links: sits between the PHY stream and the user data path on each link. It strips single-beat ping frames from the RX stream and queues a pong reply for each one. It merges pong frames into the outgoing TX stream at frame boundaries, ahead of user traffic, so the near-end link monitor sees minimal, deterministic turnaround. All other frames pass through untouched in both directions.

## Interface
Parameters:
- DATA_WIDTH, 64, stream width; must be ≥ 64.
- QUEUE_DEPTH, 4, maximum pending pongs; must be ≥ 1.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  ping detection on; when low, pings pass through as data.
- rx_data / rx_valid / rx_last  in  DATA_WIDTH/1/1  stream from the PHY.
- rx_ready  out  1  ready to the PHY.
- usr_rx_data / usr_rx_valid / usr_rx_last  out  DATA_WIDTH/1/1  non-ping frames to the user.
- usr_rx_ready  in  1  user ready.
- usr_tx_data / usr_tx_valid / usr_tx_last  in  DATA_WIDTH/1/1  user frames to send.
- usr_tx_ready  out  1  ready to the user.
- tx_data / tx_valid / tx_last  out  DATA_WIDTH/1/1  merged stream to the PHY.
- tx_ready  in  1  PHY ready.
- pending  out  $clog2(QUEUE_DEPTH+1)  queued pongs.
- pings_rx, pongs_tx, pings_dropped  out  32 each  statistics counters; wrap at 2^32.

## Operation
- **RX frame tracking.** `rx_sof` register, reset value 1.
  - Accepted beat with `rx_last` = 1 sets it.
  - Accepted beat with `rx_last` = 0 clears it.
- **Ping beat definition.** `enable` && `rx_sof` && `rx_valid` && `rx_last` && `rx_data[63:0]` == PING_MAGIC.
  - A ping beat is consumed internally: `rx_ready` = 1 and `usr_rx_valid` = 0.
  - All other beats pass through combinationally: `usr_rx_* = rx_*`, `rx_ready = usr_rx_ready`.
  - A ping must be exactly one beat and must start a frame. A magic word in mid-frame is forwarded as data.
- **Pending counter.** Pongs are constant frames, so the queue is a counter of 0..QUEUE_DEPTH.
  - Accepted ping: +1.
  - Pong handshake: −1.
  - Both in the same cycle: unchanged.
  - Ping arriving while `pending` == QUEUE_DEPTH: consumed, dropped, and `pings_dropped` increments.
- **TX arbiter states.**
  - **ST_IDLE:** `tx_valid` = 0 and `usr_tx_ready` = 0.
    - `pending` > 0 → ST_PONG.
    - Else `usr_tx_valid` → ST_USER.
    - Pong has strict priority.
  - **ST_PONG:** `tx_data` = PONG_MAGIC, zero-extended to DATA_WIDTH; `tx_last` = 1; `tx_valid` = 1; held stable until `tx_ready`. On handshake → ST_IDLE.
  - **ST_USER:** `tx_* = usr_tx_*`, `usr_tx_ready = tx_ready`. On a handshake with `usr_tx_last` → ST_IDLE.
  - A user frame is never interrupted; pongs wait for its last beat.
- **`enable` low.**
  - `pending` is forced to 0.
  - A pong already presented in ST_PONG still completes; the decrement saturates at 0.
  - User traffic is unaffected.
- **`enable` rising.** Mid-frame beats are never mistaken for pings, because `rx_sof` is tracked regardless of `enable`.

## Timing
- **Reset values.**
  - `tx_valid`, `tx_last`, `tx_data` = 0.
  - `usr_tx_ready` = 0.
  - `rx_ready` = 0 and `usr_rx_valid` = 0 while `rst` is high.
  - `pending` and all counters = 0.
  - State = ST_IDLE; `rx_sof` = 1.
- **Ping-to-pong latency.** Ping accepted in cycle N → `pending` updates at edge N+1 → ST_PONG with `tx_valid` high in cycle N+2, provided the TX side is idle and `tx_ready` is high. Latency is fixed at 2 cycles.
- **Passthrough.** RX passthrough has zero latency. TX user path has zero latency once in ST_USER.
- **Bubbles.** One idle cycle (ST_IDLE) separates consecutive TX frames.
- **Handshake rule.** `tx_data`, `tx_last`, `tx_valid` stay stable while `tx_valid` && !`tx_ready`.
- **Reset mid-frame.** Current frames are abandoned; both sides restart at frame start.

## Configuration
- Macro: `LINK_ECHO_STATS_EN`.
- **Defined:**
  - `pings_rx` increments on every accepted ping beat, including dropped ones.
  - `pongs_tx` increments on every pong handshake.
  - `pings_dropped` increments on overflow.
- **Undefined:** the three counters are tied to 0 and their registers are not built. `pending` is always present.

## Structure
- **Package `qedmma_link_pkg`**, shared by all link-health blocks:
  - PING_MAGIC = 64'h5145_444D_5049_4E47 ("QEDMPING").
  - PONG_MAGIC = 64'h5145_444D_504F_4E47 ("QEDMPONG").
  - The TX arbiter state enum.
- **Sub-module `link_tx_frame_mux`**: frame-boundary two-source arbiter with a fixed-priority source; reusable elsewhere. The remaining logic stays in the top module.

## Test plan
- **Single ping:** one ping beat in cycle 10, `tx_ready` = 1 → `usr_rx_valid` never high; `tx_valid` high in cycle 12 with `tx_data` = PONG_MAGIC and `tx_last` = 1; `pongs_tx` = 1.
- **Overflow:** QUEUE_DEPTH = 4, `tx_ready` = 0, 6 pings → `pending` = 4, `pings_dropped` = 2. Release `tx_ready` → exactly 4 pongs, separated by one-cycle gaps.
- **Pong waits for user frame:** 8-beat user frame in progress, ping arrives at beat 3 → pong is emitted only after the user beat with `usr_tx_last`, following one ST_IDLE cycle; user frame is uninterrupted.
- **Magic word mid-frame / multi-beat:** PING_MAGIC at beat 2 of a 4-beat RX frame, and a 2-beat frame starting with PING_MAGIC → all beats forwarded to `usr_rx_*`; `pings_rx` = 0.
- **Disable:** `enable` low with `pending` = 3 while a pong is presented → that pong completes, `pending` = 0, no further pongs. Pings received while disabled are forwarded as data.
- **Simultaneous events:** ping accepted in the same cycle as a pong handshake with `pending` = 2 → `pending` stays 2. Assert `rst` mid-frame → all outputs return to reset values on the next edge.
